// File: rtl/route4_32_if.sv
// Bundle of signals for the route4_32 1-to-4 router: one producer port and four consumer channels.
// Valid/ready: a word moves on a rising edge only when valid and ready are both 1; the sender holds data stable until then.
interface route4_32_if #(
   parameter int WIDTH = 32,
   parameter int CW    = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [WIDTH-1:0] out_data_0;
   logic [WIDTH-1:0] out_data_1;
   logic [WIDTH-1:0] out_data_2;
   logic [WIDTH-1:0] out_data_3;
   logic [4*CW-1:0]  occ;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3, occ
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3, occ
   );
endinterface

// File: rtl/route4_32.sv
// 1-to-4 routing stage: each accepted word is queued in the FIFO of the channel named by in_sel.
// Each channel drains independently through its own valid/ready output.
module route4_32 #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CW    = 2
) (
   input logic       clk,
   input logic       rst,
   route4_32_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [3:0]         full;
   logic [3:0]         nonempty;
   logic [4*CW-1:0]    occ_p;
   logic [4*WIDTH-1:0] head_p;

   // Full blocks the producer even if the same channel pops this cycle (no pop-through-push).
   assign bus.in_ready = !full[bus.in_sel];

   for (genvar k = 0; k < 4; k++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    wptr;
      logic [AW-1:0]    rptr;
      logic [CW-1:0]    cnt;
      logic             push;
      logic             pop;

      assign push = bus.in_valid && bus.in_ready && (bus.in_sel == 2'(k));
      assign pop  = nonempty[k] && bus.out_ready[k];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
         end else begin
            if (push) begin
               mem[wptr] <= bus.in_data;
               wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
         end
      end

      assign nonempty[k]                = (cnt != '0);
      assign full[k]                    = (cnt == CW'(DEPTH));
      assign occ_p[k*CW +: CW]          = cnt;
      assign head_p[k*WIDTH +: WIDTH]   = mem[rptr];
   end

   assign bus.out_valid  = nonempty;
   assign bus.occ        = occ_p;
   assign bus.out_data_0 = head_p[0*WIDTH +: WIDTH];
   assign bus.out_data_1 = head_p[1*WIDTH +: WIDTH];
   assign bus.out_data_2 = head_p[2*WIDTH +: WIDTH];
   assign bus.out_data_3 = head_p[3*WIDTH +: WIDTH];
endmodule

// File: tb/tb_route4_32.sv
// Directed bench for route4_32: reset, routing, backpressure, full-with-pop, streaming wrap, async reset.
module tb_route4_32;
   localparam int WIDTH = 32;
   localparam int DEPTH = 2;
   localparam int CW    = 2;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] exp_word;

   route4_32_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

   route4_32 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_sel   = 2'd0;
      bus.out_ready = 4'b0000;

      // reset then idle
      repeat (2) tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_occ", 32'(bus.occ), 32'h0);
      check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      check("rst_data0", bus.out_data_0, 32'h0);
      check("rst_data1", bus.out_data_1, 32'h0);
      check("rst_data2", bus.out_data_2, 32'h0);
      check("rst_data3", bus.out_data_3, 32'h0);

      // basic route to channel 2
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd2;
      bus.in_data  = 32'hDEADBEEF;
      #1;
      check("route_in_ready", 32'(bus.in_ready), 32'h1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      check("route_out_valid", 32'(bus.out_valid), 32'h4);
      check("route_data2", bus.out_data_2, 32'hDEADBEEF);
      check("route_occ", 32'(bus.occ), 32'h10);
      bus.out_ready = 4'b0100;
      tick();
      bus.out_ready = 4'b0000;
      #1;
      check("route_drain_valid", 32'(bus.out_valid), 32'h0);
      check("route_drain_occ", 32'(bus.occ), 32'h0);

      // fill channel 1 and apply backpressure
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd1;
      bus.in_data  = 32'h11;
      tick();
      bus.in_data  = 32'h22;
      tick();
      bus.in_data  = 32'h33;
      #1;
      check("full_in_ready", 32'(bus.in_ready), 32'h0);
      check("full_occ", 32'(bus.occ), 32'h08);
      tick();
      check("full_hold_occ", 32'(bus.occ), 32'h08);
      check("full_head", bus.out_data_1, 32'h11);
      bus.in_valid = 1'b0;
      bus.in_sel   = 2'd0;
      #1;
      check("other_sel_ready", 32'(bus.in_ready), 32'h1);

      // full channel with a same-cycle pop: pop happens, push does not
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd1;
      bus.in_data   = 32'h33;
      bus.out_ready = 4'b0010;
      #1;
      check("fullpop_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      bus.out_ready = 4'b0000;
      #1;
      check("fullpop_occ", 32'(bus.occ), 32'h04);
      check("fullpop_head", bus.out_data_1, 32'h22);
      check("fullpop_ready_after", 32'(bus.in_ready), 32'h1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      check("late_push_occ", 32'(bus.occ), 32'h08);
      bus.out_ready = 4'b0010;
      #1;
      check("drain_first", bus.out_data_1, 32'h22);
      tick();
      check("drain_second", bus.out_data_1, 32'h33);
      tick();
      bus.out_ready = 4'b0000;
      #1;
      check("drain_valid", 32'(bus.out_valid), 32'h0);
      check("drain_occ", 32'(bus.occ), 32'h0);

      // streaming through channel 3 with pointer wrap
      bus.out_ready = 4'b1000;
      bus.in_sel    = 2'd3;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in_data = 32'h100 + 32'(i);
         #1;
         if (bus.out_valid[3]) begin
            exp_word = exp_q.pop_front();
            check("stream_data", bus.out_data_3, exp_word);
         end
         check("stream_in_ready", 32'(bus.in_ready), 32'h1);
         exp_q.push_back(bus.in_data);
         tick();
         check("stream_occ", 32'(bus.occ), 32'h40);
      end
      bus.in_valid = 1'b0;
      #1;
      check("stream_last_valid", 32'(bus.out_valid), 32'h8);
      exp_word = exp_q.pop_front();
      check("stream_last_data", bus.out_data_3, exp_word);
      tick();
      bus.out_ready = 4'b0000;
      check("stream_empty", 32'(bus.out_valid), 32'h0);
      check("stream_queue_empty", 32'(exp_q.size()), 32'h0);

      // async reset with words queued in channels 0 and 3
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd0;
      bus.in_data  = 32'hA1;
      tick();
      bus.in_data  = 32'hA2;
      tick();
      bus.in_sel   = 2'd3;
      bus.in_data  = 32'hB1;
      tick();
      bus.in_data  = 32'hB2;
      tick();
      bus.in_valid = 1'b0;
      #1;
      check("pre_rst_occ", 32'(bus.occ), 32'h82);
      check("pre_rst_valid", 32'(bus.out_valid), 32'h9);
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(bus.out_valid), 32'h0);
      check("async_rst_occ", 32'(bus.occ), 32'h0);
      check("async_rst_data0", bus.out_data_0, 32'h0);
      check("async_rst_data3", bus.out_data_3, 32'h0);
      rst = 1'b0;
      tick();
      check("post_rst_valid", 32'(bus.out_valid), 32'h0);
      check("post_rst_ready", 32'(bus.in_ready), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
